// File: rtl/seg7_pkg.sv
// Shared types, segment constants and the hex-to-segment table for the
// common-anode 7-segment scan driver. Segment order is {g,f,e,d,c,b,a},
// active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  function automatic seg_t seg7_hex(input logic [3:0] n);
    seg_t s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble decoder: blank wins, then decimal-mode dash for
// nibbles above 9, otherwise the hex glyph.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  // Select the glyph for one digit.
  always_comb begin
    seg = seg7_hex(nibble);
    if (blank) begin
      seg = SEG_BLANK;
    end else if (!hex_mode && (nibble > 4'd9)) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode digits on one shared
// segment bus. New data is staged in pending registers and only becomes
// visible at a frame boundary, so one scan frame never mixes old and new
// digits. Two dead-time counts at the start of each slot keep all anodes
// off to avoid ghosting while the segment bus changes.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              HEX,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [BLK_W-1:0] blk_cnt;
  logic             phase;
  logic             tick;
  logic             wrap;

  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_bl;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_bl;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_bl;
  logic                  cur_lz;
  logic                  hide;
  logic                  live;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_sel;

  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic [NUM_DIGITS-1:0] an_p1;

  assign tick  = (cnt_p0 == CNT_W'(REFRESH_DIV - 1));
  assign wrap  = tick && (idx_p0 == IDX_W'(NUM_DIGITS - 1));
  assign frame = wrap;
  assign live  = (cnt_p0 >= CNT_W'(2));

  // Slot prescaler and digit index; the index advances once per slot.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (tick) begin
      cnt_p0 <= '0;
      idx_p0 <= (idx_p0 == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_p0 + IDX_W'(1);
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // Blink timebase: count frames, flip the visible/hidden phase on wrap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (wrap) begin
      if (blk_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

  // Pending registers hold the most recent load until the next frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_bl  <= '0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_bl  <= blink_en;
    end
  end

  // Shadow registers feed the display; a load on the wrap cycle bypasses pending.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sh_val <= '0;
      sh_dp  <= '0;
      sh_bl  <= '0;
    end else if (wrap) begin
      sh_val <= load ? value    : pend_val;
      sh_dp  <= load ? dp_in    : pend_dp;
      sh_bl  <= load ? blink_en : pend_bl;
    end
  end

  // Leading-zero mask: digit i blanks when it and every higher digit are zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (sh_val[4*i +: 4] == 4'h0);
      lz_mask[i] = blank_lz & zero_run;
    end
  end

  // Pick the shadow fields of the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_bl  = 1'b0;
    cur_lz  = 1'b0;
    an_sel  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        cur_nib   = sh_val[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_bl    = sh_bl[i];
        cur_lz    = lz_mask[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  assign hide = phase & cur_bl;

  seg7_decode u_decode (
    .nibble   (cur_nib),
    .hex_mode (hex_mode),
    .blank    (cur_lz | hide),
    .seg      (dec_seg)
  );

  // ---- stage p1: registered pin drivers ----
  // Outputs are dark during dead time; otherwise drive the scanned digit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b1;
      an_p1  <= '1;
    end else if (live) begin
      seg_p1 <= dec_seg;
      dp_p1  <= ~(cur_dp & ~hide);
      an_p1  <= an_sel;
    end else begin
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b1;
      an_p1  <= '1;
    end
  end

  assign HEX = seg_p1;
  assign DP  = dp_p1;
  assign AN  = an_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots,
// 2-frame blink). Expected pins are derived from elapsed cycles since reset
// and a log of loads: a frame shows the last load made at or before the
// cycle that ends the previous frame.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BF = 2;
  localparam int RN = RD * ND;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b1;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_en = '0;
  logic [6:0]  HEX;
  logic        DP;
  logic [3:0]  AN;
  logic        frame;

  int errors = 0;
  int checks = 0;
  int s = 0;

  int          ld_c[$];
  logic [15:0] ld_v[$];
  logic [3:0]  ld_d[$];
  logic [3:0]  ld_b[$];

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .dp_in    (dp_in),
    .blink_en (blink_en),
    .HEX      (HEX),
    .DP       (DP),
    .AN       (AN),
    .frame    (frame)
  );

  always #5 Clk = ~Clk;

  // Cycles elapsed since reset release.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) s <= 0;
    else          s <= s + 1;
  end

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Expected {AN, HEX, DP} for the pins registered while in cycle st.
  function automatic logic [11:0] model(input int st, input logic hm, input logic blz);
    int k, d, f;
    logic [15:0] v;
    logic [3:0]  dpv, bv, nib, an;
    logic [6:0]  seg;
    logic        blink, lz, dpo;
    k = st % RD;
    d = (st / RD) % ND;
    f = st / RN;
    if (k < 2) return {4'hF, 7'h7F, 1'b1};
    v = '0; dpv = '0; bv = '0;
    foreach (ld_c[i]) begin
      if (f > 0 && ld_c[i] <= f * RN - 1) begin
        v = ld_v[i]; dpv = ld_d[i]; bv = ld_b[i];
      end
    end
    an = 4'hF;
    an[d] = 1'b0;
    nib = v[4*d +: 4];
    lz = blz && (d > 0) && ((v >> (4 * d)) == 16'h0);
    blink = (((f / BF) % 2) == 1) && bv[d];
    if (blink || lz)            seg = 7'h7F;
    else if (!hm && nib > 4'd9) seg = 7'h3F;
    else                        seg = hexseg(nib);
    dpo = blink ? 1'b1 : ~dpv[d];
    return {an, seg, dpo};
  endfunction

  task automatic test_reset();
    logic [12:0] exp;
    #2 Reset_n = 1'b0;
    #1;
    exp = {4'hF, 7'h7F, 1'b1, 1'b0};
    checks++;
    if ({AN, HEX, DP, frame} !== exp) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {AN, HEX, DP, frame}, exp);
    end
    ld_c.delete(); ld_v.delete(); ld_d.delete(); ld_b.delete();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [12:0] exp;
    for (int i = 0; i < 3 * RN; i++) begin
      @(negedge Clk);
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL scan s=%0d got=%h exp=%h", s, {AN, HEX, DP, frame}, exp);
      end
    end
  endtask

  task automatic test_load_hex();
    logic [12:0] exp;
    bit done = 0;
    hex_mode = 1'b1; blank_lz = 1'b0;
    for (int i = 0; i < 3 * RN; i++) begin
      @(negedge Clk);
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL load_hex s=%0d got=%h exp=%h", s, {AN, HEX, DP, frame}, exp);
      end
      load = 1'b0;
      if (!done && (s % RN) == 12) begin
        done = 1;
        load = 1'b1; value = 16'h1A3F; dp_in = 4'h0; blink_en = 4'h0;
        ld_c.push_back(s); ld_v.push_back(value); ld_d.push_back(dp_in); ld_b.push_back(blink_en);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_lz();
    logic [12:0] exp;
    for (int i = 0; i < 8 * RN; i++) begin
      @(negedge Clk);
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL lz s=%0d hm=%0b blz=%0b got=%h exp=%h", s, hex_mode, blank_lz,
                 {AN, HEX, DP, frame}, exp);
      end
      load = 1'b0;
      if (i == 0) begin
        hex_mode = 1'b0; blank_lz = 1'b1;
        load = 1'b1; value = 16'h0070; dp_in = 4'h0; blink_en = 4'h0;
      end else if (i == 3 * RN) begin
        blank_lz = 1'b0;
      end else if (i == 5 * RN) begin
        load = 1'b1; value = 16'h0C00;
      end else if (i == 7 * RN) begin
        blank_lz = 1'b1;
      end
      if (load) begin
        ld_c.push_back(s); ld_v.push_back(value); ld_d.push_back(dp_in); ld_b.push_back(blink_en);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_blink_dp();
    logic [12:0] exp;
    for (int i = 0; i < 9 * RN; i++) begin
      @(negedge Clk);
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL blink_dp s=%0d got=%h exp=%h", s, {AN, HEX, DP, frame}, exp);
      end
      load = 1'b0;
      if (i == 0) begin
        hex_mode = 1'b1; blank_lz = 1'b0;
        load = 1'b1; value = 16'($urandom) | 16'h1111; dp_in = 4'b0001; blink_en = 4'b0010;
        ld_c.push_back(s); ld_v.push_back(value); ld_d.push_back(dp_in); ld_b.push_back(blink_en);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp;
    bit hit = 0;
    hex_mode = 1'b1; blank_lz = 1'b0;
    for (int i = 0; i < RN + 2 && !hit; i++) begin
      @(negedge Clk);
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL wait_frame s=%0d got=%h exp=%h", s, {AN, HEX, DP, frame}, exp);
      end
      if (frame) begin
        hit = 1;
        load = 1'b1; value = 16'h5555; dp_in = 4'h0; blink_en = 4'h0;
        ld_c.push_back(s); ld_v.push_back(value); ld_d.push_back(dp_in); ld_b.push_back(blink_en);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL frame_timeout got=0 exp=1");
    end
    for (int i = 0; i < 2 * RN; i++) begin
      @(negedge Clk);
      load = 1'b0;
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL bypass s=%0d got=%h exp=%h", s, {AN, HEX, DP, frame}, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    for (int i = 0; i < 20 * RN; i++) begin
      @(negedge Clk);
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL random s=%0d hm=%0b blz=%0b got=%h exp=%h", s, hex_mode, blank_lz,
                 {AN, HEX, DP, frame}, exp);
      end
      load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        load = 1'b1;
        value = 16'($urandom);
        if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(1, 3));
        dp_in = 4'($urandom); blink_en = 4'($urandom);
        ld_c.push_back(s); ld_v.push_back(value); ld_d.push_back(dp_in); ld_b.push_back(blink_en);
      end
      if ($urandom_range(0, 47) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 47) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp;
    bit hit = 0;
    for (int i = 0; i < RN + 2 && !hit; i++) begin
      @(negedge Clk);
      if (AN == 4'b1011) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL an_1011_timeout got=%b exp=1011", AN);
    end
    #1 Reset_n = 1'b0;
    #1;
    exp = {4'hF, 7'h7F, 1'b1, 1'b0};
    checks++;
    if ({AN, HEX, DP, frame} !== exp) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", {AN, HEX, DP, frame}, exp);
    end
    ld_c.delete(); ld_v.delete(); ld_d.delete(); ld_b.delete();
    hex_mode = 1'b1; blank_lz = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 2 * RN; i++) begin
      @(negedge Clk);
      exp = {model(s - 1, hex_mode, blank_lz), 1'(s % RN == RN - 1)};
      checks++;
      if ({AN, HEX, DP, frame} !== exp) begin
        errors++;
        $display("FAIL restart s=%0d got=%h exp=%h", s, {AN, HEX, DP, frame}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_hex();
    test_lz();
    test_blink_dp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
